// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct select or automatic scan rotation.
// Define SCAN_DECODER_ACTIVE_LOW_EN to drive y active-low (blank = all ones).
module scan_decoder #(
    parameter int SEL_W = 2,
    parameter int DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  step
);

    localparam int OUT_W = 2**SEL_W;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);
    localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] Y_OFF = '1;
`else
    localparam logic [OUT_W-1:0] Y_OFF = '0;
`endif

    logic [OUT_W-1:0] r_y;
    logic [SEL_W-1:0] r_idx;
    logic             r_step;
    logic [PW-1:0]    r_pre;
    logic             r_mode_q;

    logic [OUT_W-1:0] w_hot;
    logic [SEL_W-1:0] w_idx_nxt;
    logic [PW-1:0]    w_pre_nxt;
    logic             w_step_nxt;

    always_comb begin
        w_idx_nxt  = r_idx;
        w_pre_nxt  = r_pre;
        w_step_nxt = 1'b0;
        if (en) begin
            if (!mode) begin
                w_idx_nxt = sel;
                w_pre_nxt = '0;
            end else if (!r_mode_q) begin
                // entering scan: keep last direct index, restart period
                w_pre_nxt = '0;
            end else if (r_pre == PRE_MAX) begin
                w_pre_nxt  = '0;
                w_idx_nxt  = r_idx + SEL_W'(1);
                w_step_nxt = 1'b1;
            end else begin
                w_pre_nxt = r_pre + PW'(1);
            end
        end
        w_hot = en ? (ONE << w_idx_nxt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y      <= Y_OFF;
            r_idx    <= '0;
            r_step   <= 1'b0;
            r_pre    <= '0;
            r_mode_q <= 1'b0;
        end else begin
            r_y      <= w_hot ^ Y_OFF;
            r_idx    <= w_idx_nxt;
            r_step   <= w_step_nxt;
            r_pre    <= w_pre_nxt;
            r_mode_q <= mode;
        end
    end

    assign y    = r_y;
    assign idx  = r_idx;
    assign step = r_step;

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable. Generalises the fixed 2-to-4 decoder.
- Two modes:
  - Direct mode: decodes the `sel` input.
  - Scan mode: an internal prescaler and index counter rotate the one-hot output automatically.
- Target use: seven-segment anode/digit scanning and row strobing on the board.

Parameters:
- SEL_W, 2, select/index width; output width OUT_W = 2**SEL_W (derived localparam, not overridable).
- DIV, 4, clocks per scan step in scan mode; legal range 1..2**24; prescaler width = max(1, clog2(DIV)).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  output enable; 0 blanks outputs and freezes counters
- mode  in  1  0 = direct decode of sel, 1 = automatic scan
- sel  in  SEL_W  index to decode in direct mode; ignored in scan mode
- y  out  OUT_W  registered one-hot decode of idx (all-zero when blanked)
- idx  out  SEL_W  currently decoded index (registered)
- step  out  1  one-cycle pulse on the edge where idx advances in scan mode

Behaviour:
- Reset (async assert, sync use after deassert): y=0, idx=0, step=0, prescaler=0, mode_q=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Invariant: y is either all-zero or exactly one-hot with y[idx]=1.
- mode_q = mode registered each cycle regardless of en. A mode change is detected when mode != mode_q.
- en=0:
  - y <= 0; step <= 0.
  - idx, prescaler and mode_q handling still apply (mode_q tracks mode), but idx and prescaler hold.
- en=1, direct mode (mode=0):
  - idx <= sel; y <= 1 << sel; step <= 0; prescaler <= 0.
  - Latency: 1 clock from sel to y.
- en=1, scan mode (mode=1), steady state (mode_q=1):
  - If prescaler == DIV-1: prescaler <= 0; idx <= idx+1 mod OUT_W (OUT_W-1 wraps to 0); y <= 1 << (idx+1 mod OUT_W); step <= 1.
  - Otherwise: prescaler <= prescaler+1; idx holds; y <= 1 << idx; step <= 0.
  - Each index is held for exactly DIV cycles.
- Mode change direct->scan (mode=1, mode_q=0):
  - prescaler <= 0; idx holds its last direct value; y <= 1 << idx; step <= 0.
  - The first advance occurs DIV cycles later.
- Mode change scan->direct: covered by the direct rule. idx <= sel and prescaler cleared on the first direct cycle.
- DIV=1: idx advances and step pulses every enabled scan cycle.
- Re-enable (en 0->1) in scan mode: prescaler resumes from its held value. No extra step pulse.
- Reset mid-scan: all state returns to reset values immediately. The scan restarts from idx=0 with a full DIV period.
- sel values are always in range; no out-of-range case exists.

Optional Feature:
- Macro: SCAN_DECODER_ACTIVE_LOW_EN.
- Defined:
  - y is driven inverted: active-low one-hot. Blanked/reset value is all-ones, e.g. 4'b1111 for SEL_W=2; selected bit is 0.
  - idx and step are unaffected.
- Undefined: active-high as described above; reset/blank value is all-zeros.

Test Plan (SEL_W=2, DIV=4, macro undefined unless stated):
- Reset and direct decode:
  - Assert rst mid-cycle -> y=0, idx=0, step=0 immediately.
  - Release, en=1, mode=0, sel=0,1,2,3 on consecutive cycles -> y=0001,0010,0100,1000, each one clock after sel.
- Scan rotation and wrap:
  - en=1, mode=1 from idx=0 -> y=0001 for 4 cycles, then 0010, 0100, 1000, then 0001 (wrap).
  - step pulses for exactly 1 cycle on each advance, 4 clocks apart.
- Enable blanking:
  - During scan at idx=2, prescaler=1, drop en for 5 cycles -> y=0 and step=0 throughout.
  - On re-enable: y=0100, then 2 more cycles before advancing to 1000.
- Mode switching:
  - Direct sel=3, then set mode=1 -> y=1000 held for 4 cycles, then 0001.
  - Mid-scan set mode=0 with sel=1 -> next cycle y=0010, step=0.
- Reset mid-operation:
  - Assert rst while idx=3 in scan -> y=0, idx=0.
  - After release in scan -> y=0001 held 4 cycles before first step.
- Active-low build (SCAN_DECODER_ACTIVE_LOW_EN defined):
  - Reset -> y=1111.
  - Direct sel=2 -> y=1011.
  - en=0 -> y=1111.
